// File: rtl/kypd_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : kypd_scanner                                                  |
// | Brief    : 4x4 matrix keypad scanner with frame debounce and press event |
// | Option   : KYPD_GHOST_REJECT_EN drops frames with 3+ keys (ghosting)     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module kypd_scanner #(
  parameter int SCAN_DIV  = 100000,
  parameter int DEB_SCANS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [15:0] keys,
  output logic        key_any,
  output logic        key_press,
  output logic [3:0]  key_code
);

  localparam int c_div_w = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int c_cnt_w = (DEB_SCANS > 1) ? $clog2(DEB_SCANS) : 1;
  localparam logic [c_div_w-1:0] c_div_max = c_div_w'(SCAN_DIV - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEB_SCANS - 1);

  localparam logic [1:0] c_st_drive  = 2'd0;
  localparam logic [1:0] c_st_sample = 2'd1;
  localparam logic [1:0] c_st_eval   = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [c_div_w-1:0] r_div;
  logic [1:0]         r_colidx;
  logic [3:0]         r_row_s1;
  logic [3:0]         r_row_s2;
  logic [15:0]        r_acc;
  logic [15:0]        r_prev;
  logic [c_cnt_w-1:0] r_cnt;
  logic [15:0]        r_keys;
  logic               r_key_any;
  logic               r_key_press;
  logic [3:0]         r_key_code;

  logic               w_sample;
  logic               w_eval;
  logic               w_ghost;
  logic [c_cnt_w-1:0] w_cnt_nxt;
  logic               w_update;
  logic [15:0]        w_new;
  logic [3:0]         w_code;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= c_st_drive;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_drive:  if (r_div == c_div_max) w_state_nxt = c_st_sample;
      c_st_sample: w_state_nxt = (r_colidx == 2'd3) ? c_st_eval : c_st_drive;
      c_st_eval:   w_state_nxt = c_st_drive;
      default:     w_state_nxt = c_st_drive;
    endcase
  end

  always_comb begin
    w_sample = (r_state == c_st_sample);
    w_eval   = (r_state == c_st_eval);
    col      = ~(4'b0001 << r_colidx);
  end

`ifdef KYPD_GHOST_REJECT_EN
  logic [4:0] w_pop;
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < 16; i++) w_pop = w_pop + {4'b0000, r_acc[i]};
  end
  assign w_ghost = (w_pop >= 5'd3);
`else
  assign w_ghost = 1'b0;
`endif

  // Debounce decision and lowest-new-key encoder for the frame under evaluation
  always_comb begin
    if (r_acc != r_prev)        w_cnt_nxt = '0;
    else if (r_cnt == c_cnt_max) w_cnt_nxt = r_cnt;
    else                        w_cnt_nxt = r_cnt + 1'b1;
    w_update = (w_cnt_nxt == c_cnt_max) && (r_acc != r_keys) && !w_ghost;
    w_new    = r_acc & ~r_keys;
    w_code   = '0;
    for (int i = 15; i >= 0; i--) begin
      if (w_new[i]) w_code = 4'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_div       <= '0;
      r_colidx    <= '0;
      r_row_s1    <= '0;
      r_row_s2    <= '0;
      r_acc       <= '0;
      r_prev      <= '0;
      r_cnt       <= '0;
      r_keys      <= '0;
      r_key_any   <= 1'b0;
      r_key_press <= 1'b0;
      r_key_code  <= '0;
    end else begin
      r_row_s1    <= ~row;
      r_row_s2    <= r_row_s1;
      r_key_press <= 1'b0;

      if ((r_state == c_st_drive) && (r_div != c_div_max)) begin
        r_div <= r_div + 1'b1;
      end else begin
        r_div <= '0;
      end

      if (w_sample) begin
        r_acc[{r_colidx, 2'b00} +: 4] <= r_row_s2;
        if (r_colidx != 2'd3) r_colidx <= r_colidx + 2'd1;
      end

      if (w_eval) begin
        if (w_ghost) begin
          r_cnt <= '0;
        end else begin
          r_cnt  <= w_cnt_nxt;
          r_prev <= r_acc;
        end
        if (w_update) begin
          r_keys    <= r_acc;
          r_key_any <= |r_acc;
          if (|w_new) begin
            r_key_press <= 1'b1;
            r_key_code  <= w_code;
          end
        end
        r_acc    <= '0;
        r_colidx <= '0;
      end
    end
  end

  assign keys      = r_keys;
  assign key_any   = r_key_any;
  assign key_press = r_key_press;
  assign key_code  = r_key_code;

endmodule
`default_nettype wire

// File: tb/tb_kypd_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_kypd_scanner                                               |
// | Brief    : Directed bench for kypd_scanner with a simple keypad model    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_kypd_scanner;

  localparam int SCAN_DIV  = 4;
  localparam int DEB_SCANS = 3;
  localparam int FRAME     = 21;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [15:0] keys;
  logic        key_any;
  logic        key_press;
  logic [3:0]  key_code;
  logic [15:0] pressed = '0;

  int total = 0;
  int bad = 0;
  int cyc_n = 0;
  int press_cnt = 0;

  always #5 clk = ~clk;

  kypd_scanner #(.SCAN_DIV(SCAN_DIV), .DEB_SCANS(DEB_SCANS)) dut (
    .clk       (clk),
    .reset     (reset),
    .row       (row),
    .col       (col),
    .keys      (keys),
    .key_any   (key_any),
    .key_press (key_press),
    .key_code  (key_code)
  );

  // Keypad matrix: a pressed key pulls its row low while its column is driven
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++) begin
      if (!col[c]) begin
        for (int r = 0; r < 4; r++) begin
          if (pressed[c*4+r]) row[r] = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) if (reset && key_press) press_cnt <= press_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic run_to(input int n);
    while (cyc_n < n) tick();
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_col(input int n);
    int p;
    p = n % FRAME;
    if (p < 5)       return 4'b1110;
    else if (p < 10) return 4'b1101;
    else if (p < 15) return 4'b1011;
    else             return 4'b0111;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_col", {12'h0, col}, 16'h000E);
    check("rst_keys", keys, 16'h0000);
    check("rst_any", {15'h0, key_any}, 16'h0000);
    check("rst_press", {15'h0, key_press}, 16'h0000);
    check("rst_code", {12'h0, key_code}, 16'h0000);
    reset = 1'b1;
    cyc_n = 0;

    // Idle keypad: column walk and quiet outputs for 10 frames
    for (int n = 0; n < 10 * FRAME; n++) begin
      check("idle_col", {12'h0, col}, {12'h0, exp_col(cyc_n)});
      check("idle_keys", keys, 16'h0000);
      tick();
    end
    check("idle_presses", 16'(press_cnt), 16'd0);

    // Key 5 held from frame 11; update after the 3rd identical frame
    pressed = 16'h0020;
    run_to(272);
    check("k5_early", keys, 16'h0000);
    tick();
    check("k5_keys", keys, 16'h0020);
    check("k5_any", {15'h0, key_any}, 16'h0001);
    check("k5_press", {15'h0, key_press}, 16'h0001);
    check("k5_code", {12'h0, key_code}, 16'h0005);
    tick();
    check("k5_pulse_end", {15'h0, key_press}, 16'h0000);
    check("k5_presses", 16'(press_cnt), 16'd1);

    pressed = 16'h0021;
    run_to(335);
    check("k50_early", keys, 16'h0020);
    tick();
    check("k50_keys", keys, 16'h0021);
    check("k50_press", {15'h0, key_press}, 16'h0001);
    check("k50_code", {12'h0, key_code}, 16'h0000);
    tick();
    check("k50_presses", 16'(press_cnt), 16'd2);

    pressed = 16'h0000;
    run_to(398);
    check("rel_early", keys, 16'h0021);
    tick();
    check("rel_keys", keys, 16'h0000);
    check("rel_any", {15'h0, key_any}, 16'h0000);
    check("rel_press", {15'h0, key_press}, 16'h0000);
    check("rel_code", {12'h0, key_code}, 16'h0000);
    check("rel_presses", 16'(press_cnt), 16'd2);

    // Key 10 present in frames 20,21, absent in 22, present again from 23
    pressed = 16'h0400;
    run_to(441);
    pressed = 16'h0000;
    run_to(462);
    check("glitch_f22", keys, 16'h0000);
    pressed = 16'h0400;
    run_to(504);
    check("glitch_f24", keys, 16'h0000);
    run_to(524);
    check("glitch_f25_pre", keys, 16'h0000);
    tick();
    check("k10_keys", keys, 16'h0400);
    check("k10_press", {15'h0, key_press}, 16'h0001);
    check("k10_code", {12'h0, key_code}, 16'h000A);
    pressed = 16'h8000;

    // Reset in the middle of column 2 while key 15 is held
    run_to(537);
    check("mid_col2", {12'h0, col}, 16'h000B);
    reset = 1'b0;
    tick();
    check("mr_col", {12'h0, col}, 16'h000E);
    check("mr_keys", keys, 16'h0000);
    check("mr_any", {15'h0, key_any}, 16'h0000);
    check("mr_press", {15'h0, key_press}, 16'h0000);
    check("mr_code", {12'h0, key_code}, 16'h0000);
    reset = 1'b1;
    cyc_n = 0;
    run_to(62);
    check("k15_early", keys, 16'h0000);
    tick();
    check("k15_keys", keys, 16'h8000);
    check("k15_press", {15'h0, key_press}, 16'h0001);
    check("k15_code", {12'h0, key_code}, 16'h000F);
    tick();
    check("k15_presses", 16'(press_cnt), 16'd4);

    // Three keys forming a ghosting pattern, from a fresh reset
    pressed = 16'h0013;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    cyc_n = 0;
    run_to(63);
`ifdef KYPD_GHOST_REJECT_EN
    check("ghost_keys", keys, 16'h0000);
    check("ghost_press", {15'h0, key_press}, 16'h0000);
    run_to(130);
    check("ghost_keys_late", keys, 16'h0000);
    check("ghost_presses", 16'(press_cnt), 16'd4);
`else
    check("three_keys", keys, 16'h0013);
    check("three_any", {15'h0, key_any}, 16'h0001);
    check("three_press", {15'h0, key_press}, 16'h0001);
    check("three_code", {12'h0, key_code}, 16'h0000);
    tick();
    check("three_presses", 16'(press_cnt), 16'd5);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
